// File: rtl/dda_param_loader_if.sv
// Pin-side and core-side signal bundle of the DDA parameter loader.
// master = pin driver / core, slave = the loader itself.
interface dda_param_loader_if #(
    parameter int N = 16
);
    logic [7:0]   data_in;
    logic         strobe;
    logic         run;
    logic [N-1:0] icx;
    logic [N-1:0] icy;
    logic [N-1:0] mu;
    logic         dda_rst_n;
    logic         busy;
    logic [2:0]   byte_idx;
    logic         loaded;
    logic         timeout_err;

    modport master (
        output data_in, strobe, run,
        input  icx, icy, mu, dda_rst_n, busy, byte_idx, loaded, timeout_err
    );

    modport slave (
        input  data_in, strobe, run,
        output icx, icy, mu, dda_rst_n, busy, byte_idx, loaded, timeout_err
    );
endinterface

// File: rtl/dda_param_loader.sv
// Assembles icx/icy/mu for the posit Van der Pol DDA core from six strobed pin bytes
// and holds the core in reset until a run request arrives.
module dda_param_loader #(
    parameter int           N       = 16,
    parameter logic [N-1:0] DEF_ICX = 16'h4000,
    parameter logic [N-1:0] DEF_ICY = 16'h0000,
    parameter logic [N-1:0] DEF_MU  = 16'h4000,
    parameter int           TIMEOUT = 1000000
) (
    input logic              clk,
    input logic              rst_n,
    dda_param_loader_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    logic          strobe_s1, strobe_s2, strobe_s3;
    logic          run_s1, run_s2;
    logic [7:0]    data_s1, data_s2;
    logic [39:0]   shadow;
    logic [CW-1:0] idle_cnt;
    logic [N-1:0]  icx_q, icy_q, mu_q;
    logic          dda_rst_n_q, busy_q, loaded_q, timeout_err_q;
    logic [2:0]    byte_idx_q;
    logic          strobe_edge;

    // data_s2 lines up with the strobe edge: it holds data_in sampled when strobe was first seen high.
    assign strobe_edge = strobe_s2 & ~strobe_s3;

    // NOTE: every register here is written with <= so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            strobe_s1     <= 1'b0;
            strobe_s2     <= 1'b0;
            strobe_s3     <= 1'b0;
            run_s1        <= 1'b0;
            run_s2        <= 1'b0;
            data_s1       <= '0;
            data_s2       <= '0;
            shadow        <= '0;
            idle_cnt      <= '0;
            icx_q         <= DEF_ICX;
            icy_q         <= DEF_ICY;
            mu_q          <= DEF_MU;
            dda_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            byte_idx_q    <= '0;
            loaded_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            strobe_s1 <= bus.strobe;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
            run_s1    <= bus.run;
            run_s2    <= run_s1;
            data_s1   <= bus.data_in;
            data_s2   <= data_s1;

            case (state)
                IDLE: begin
                    dda_rst_n_q <= 1'b0;
                    if (strobe_edge) begin
                        shadow[39:32] <= data_s2;
                        byte_idx_q    <= 3'd1;
                        idle_cnt      <= '0;
                        busy_q        <= 1'b1;
                        state         <= LOAD;
                    end else if (run_s2) begin
                        state <= RUN;
                    end
                end

                LOAD: begin
                    dda_rst_n_q <= 1'b0;
                    if (strobe_edge) begin
                        idle_cnt <= '0;
                        case (byte_idx_q)
                            3'd1:    shadow[31:24] <= data_s2;
                            3'd2:    shadow[23:16] <= data_s2;
                            3'd3:    shadow[15:8]  <= data_s2;
                            3'd4:    shadow[7:0]   <= data_s2;
                            default: ;
                        endcase
                        if (byte_idx_q == 3'd5) begin
                            // All three words change on one edge so the core never sees a mixed set.
                            icx_q      <= shadow[39:24];
                            icy_q      <= shadow[23:8];
                            mu_q       <= {shadow[7:0], data_s2};
                            loaded_q   <= 1'b1;
                            byte_idx_q <= '0;
                            busy_q     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        shadow        <= '0;
                        idle_cnt      <= '0;
                        byte_idx_q    <= '0;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end

                RUN: begin
                    // Dropping dda_rst_n on exit makes the core reload icx/icy on the next run.
                    if (!run_s2) begin
                        dda_rst_n_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        dda_rst_n_q <= 1'b1;
                    end
                end

                default: begin
                    dda_rst_n_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.icx         = icx_q;
    assign bus.icy         = icy_q;
    assign bus.mu          = mu_q;
    assign bus.dda_rst_n   = dda_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.byte_idx    = byte_idx_q;
    assign bus.loaded      = loaded_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_dda_param_loader.sv
// Scoreboard bench for dda_param_loader: stimulus queues expected output snapshots
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_dda_param_loader;
  localparam int TMO = 16;

  typedef struct {
    int unsigned at;
    string       name;
    logic [15:0] icx;
    logic [15:0] icy;
    logic [15:0] mu;
    logic        rst;
    logic        busy;
    logic [2:0]  idx;
    logic        loaded;
    logic        terr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dda_param_loader_if #(.N(16)) bus ();

  dda_param_loader #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passed = 0;

  logic [15:0] m_icx, m_icy, m_mu;
  logic        m_rst, m_loaded, m_terr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned at, input string name,
                           input logic [2:0] idx, input logic busy);
    exp_t e;
    e.at = at; e.name = name;
    e.icx = m_icx; e.icy = m_icy; e.mu = m_mu;
    e.rst = m_rst; e.busy = busy; e.idx = idx;
    e.loaded = m_loaded; e.terr = m_terr;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [54:0] act, want;
    act  = {bus.icx, bus.icy, bus.mu, bus.dda_rst_n, bus.busy, bus.byte_idx,
            bus.loaded, bus.timeout_err};
    want = {e.icx, e.icy, e.mu, e.rst, e.busy, e.idx, e.loaded, e.terr};
    checks++;
    if (act === want) passed++;
    else
      $display("FAIL %s @cyc %0d: got icx=%h icy=%h mu=%h rst_n=%b busy=%b idx=%0d loaded=%b terr=%b; want icx=%h icy=%h mu=%h rst_n=%b busy=%b idx=%0d loaded=%b terr=%b",
               e.name, cyc, bus.icx, bus.icy, bus.mu, bus.dda_rst_n, bus.busy,
               bus.byte_idx, bus.loaded, bus.timeout_err, e.icx, e.icy, e.mu,
               e.rst, e.busy, e.idx, e.loaded, e.terr);
  endtask

  // Monitor: compare every entry due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        $display("FAIL %s missed: due cyc %0d, now cyc %0d", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Data one cycle early, strobe high two cycles; capture lands 4 edges after the call.
  task automatic do_byte(input logic [7:0] b, input logic [2:0] idx, input logic busy,
                         input string name);
    expect_at(cyc + 4, name, idx, busy);
    bus.data_in = b;
    step(1);
    bus.strobe = 1'b1;
    step(2);
    bus.strobe = 1'b0;
    step(1);
  endtask

  task automatic load6(input logic [47:0] bytes);
    for (int i = 0; i < 5; i++)
      do_byte(bytes[47-8*i -: 8], 3'(i + 1), 1'b1, "load_byte");
    expect_at(cyc + 3, "pre_commit", 3'd5, 1'b1);
    m_icx = bytes[47:32];
    m_icy = bytes[31:16];
    m_mu = bytes[15:0];
    m_loaded = 1'b1;
    do_byte(bytes[7:0], 3'd0, 1'b0, "commit");
  endtask

  task automatic model_reset();
    m_icx = 16'h4000; m_icy = 16'h0000; m_mu = 16'h4000;
    m_rst = 1'b0; m_loaded = 1'b0; m_terr = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.data_in = 8'h00;
    bus.strobe = 1'b0;
    bus.run = 1'b0;
    step(3);
    expect_at(cyc + 1, "reset_state", 3'd0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Full load from the plan.
    load6(48'h3C00_0000_3800);
    step(4);

    // Partial load then silence: abort exactly TMO cycles after the last capture.
    do_byte(8'h11, 3'd1, 1'b1, "partial_b0");
    do_byte(8'h22, 3'd2, 1'b1, "partial_b1");
    do_byte(8'h33, 3'd3, 1'b1, "partial_b2");
    do_byte(8'h44, 3'd4, 1'b1, "partial_b3");
    expect_at(cyc + TMO - 1, "pre_timeout", 3'd4, 1'b1);
    m_terr = 1'b1;
    expect_at(cyc + TMO, "timeout_abort", 3'd0, 1'b0);
    step(TMO + 4);
    load6(48'h1234_5678_9ABC);
    step(4);

    // Run from IDLE: dda_rst_n rises 4 edges after run is driven.
    bus.run = 1'b1;
    expect_at(cyc + 3, "run_pre", 3'd0, 1'b0);
    m_rst = 1'b1;
    expect_at(cyc + 4, "run_high", 3'd0, 1'b0);
    step(6);
    do_byte(8'hFF, 3'd0, 1'b0, "strobe_in_run_a");
    do_byte(8'hEE, 3'd0, 1'b0, "strobe_in_run_b");
    step(2);
    bus.run = 1'b0;
    expect_at(cyc + 2, "run_drop_pre", 3'd0, 1'b0);
    m_rst = 1'b0;
    expect_at(cyc + 3, "run_low", 3'd0, 1'b0);
    step(5);

    // run raised mid-load: stays in LOAD, enters RUN after the commit.
    do_byte(8'h01, 3'd1, 1'b1, "runload_b0");
    do_byte(8'h02, 3'd2, 1'b1, "runload_b1");
    do_byte(8'h03, 3'd3, 1'b1, "runload_b2");
    bus.run = 1'b1;
    do_byte(8'h04, 3'd4, 1'b1, "runload_b3");
    do_byte(8'h05, 3'd5, 1'b1, "runload_b4");
    m_icx = 16'h0102; m_icy = 16'h0304; m_mu = 16'h0506; m_loaded = 1'b1;
    do_byte(8'h06, 3'd0, 1'b0, "runload_commit");
    expect_at(cyc + 1, "run_after_commit_pre", 3'd0, 1'b0);
    m_rst = 1'b1;
    expect_at(cyc + 2, "run_after_commit", 3'd0, 1'b0);
    step(4);
    bus.run = 1'b0;
    m_rst = 1'b0;
    expect_at(cyc + 3, "run_low_again", 3'd0, 1'b0);
    step(5);

    // Reset in the middle of a load, then a clean reload.
    do_byte(8'h0A, 3'd1, 1'b1, "midrst_b0");
    do_byte(8'h0B, 3'd2, 1'b1, "midrst_b1");
    do_byte(8'h0C, 3'd3, 1'b1, "midrst_b2");
    rst_n = 1'b0;
    model_reset();
    expect_at(cyc + 1, "mid_load_reset", 3'd0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    load6(48'hDEAD_BEEF_CAFE);
    step(5);

    while (sb.size() > 0) begin
      checks++;
      $display("FAIL %s never checked: due cyc %0d", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dda_param_loader.md
Name: dda_param_loader

Overview:
- Upstream stage of the posit Van der Pol DDA core. Assembles the three 16-bit posit operands (icx, icy, mu) from a byte-wide pin bus using a strobe pin.
- Holds the core in reset while parameters are loaded, then releases it on a run request.
- Outputs connect directly to the core's icx, icy, mu and rst_n inputs.

Parameters:
N, 16, posit word width; fixed at 16 for the byte sequencing.
DEF_ICX, 16'h4000, icx after reset (posit 1.0, ES=1).
DEF_ICY, 16'h0000, icy after reset (posit 0).
DEF_MU, 16'h4000, mu after reset (posit 1.0).
TIMEOUT, 1000000, idle cycles allowed between bytes of one load before the load is aborted.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
data_in  input  8  parameter byte from pins (asynchronous)
strobe  input  1  byte strobe from pin (asynchronous); rising edge = byte valid
run  input  1  run request level from pin (asynchronous)
icx  output  N  committed initial x
icy  output  N  committed initial y
mu  output  N  committed mu
dda_rst_n  output  1  reset to the DDA core, active low, registered
busy  output  1  high while a load is in progress
byte_idx  output  3  index of the next byte expected (0..5)
loaded  output  1  sticky; set on the first completed load after reset
timeout_err  output  1  sticky; set when a partial load is aborted

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. All state changes on the rising edge of clk.
- Reset values: icx=DEF_ICX, icy=DEF_ICY, mu=DEF_MU, dda_rst_n=0, busy=0, byte_idx=0, loaded=0, timeout_err=0. FSM goes to IDLE, timeout counter=0, all sync flops=0.
- Synchronisers:
  - strobe and run each pass through 2 flops (s1, s2). Strobe has a third flop s3; edge = s2 & !s3.
  - data_in passes through 2 flops aligned with strobe. The captured byte is data_in as sampled on the same edge strobe was first sampled high.
  - A byte is captured on the 3rd rising edge counting the edge that first samples strobe high.
  - data_in must be stable from 1 cycle before to 2 cycles after the strobe rise.
- Byte order: 0=icx[15:8], 1=icx[7:0], 2=icy[15:8], 3=icy[7:0], 4=mu[15:8], 5=mu[7:0].
- Bytes 0..4 go into a 40-bit shadow register. Byte 5 commits the shadow plus byte 5 to icx/icy/mu on that same edge, atomically. Partial loads never change icx/icy/mu.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: dda_rst_n=0.
    - Strobe edge: capture byte 0 → LOAD, byte_idx=1, counter cleared.
    - Else if run_s2=1 → RUN.
    - Strobe edge takes priority over run on the same cycle.
  - LOAD: busy=1, dda_rst_n=0.
    - Each strobe edge captures byte at byte_idx, increments byte_idx, clears counter.
    - Capture of byte 5: commit, set loaded, byte_idx=0 → IDLE.
    - No edge: counter increments. Counter reaching TIMEOUT-1 with no edge: discard shadow, byte_idx=0, set timeout_err → IDLE.
    - Edge and timeout on the same cycle: the edge wins.
    - run is ignored in LOAD.
  - RUN: dda_rst_n=1 (registered, so it is high from the edge after entry).
    - run_s2=0 → IDLE; dda_rst_n=0 on that edge, so the core reloads icx/icy.
    - Strobe edges in RUN are ignored: no capture, byte_idx unchanged.
- No loaded precondition for RUN: the core may run with default parameters.
- byte_idx wraps only through commit or abort. It never reaches 6.
- Reset mid-load or mid-run: next state is the full reset state. Shadow is discarded, committed values return to defaults.
- timeout_err and loaded clear only on rst_n.

Test Plan:
- Reset with run=0, strobe=0 → icx=4000, icy=0000, mu=4000, dda_rst_n=0, busy=0, byte_idx=0, flags 0.
- Six strobed bytes 3C,00,00,00,38,00 (4 cycles each, strobe high for 2 cycles) → icx=3C00, icy=0000, mu=3800 on the 6th capture edge; before that edge icx/icy/mu unchanged; busy high between the 1st and 6th captures; loaded=1 after.
- Four bytes, then silence with TIMEOUT=16 → abort exactly 16 cycles after the last capture; timeout_err=1, byte_idx=0, icx/icy/mu unchanged; a following full load succeeds.
- Raise run in IDLE → dda_rst_n=1 on the 3rd edge after run is first sampled high; drop run → dda_rst_n=0 three edges later.
- Strobe pulses during RUN → byte_idx stays 0 and outputs are unchanged. run raised mid-LOAD → stays LOAD; enters RUN only after commit if run is still high.
- rst_n low after 3 bytes of a load → all reset values next edge; a 6-byte reload then commits cleanly.
